// File: rtl/asteroid_pkg.sv
// Shared constants and types for the asteroid table controller.
package asteroid_pkg;

   localparam int unsigned ASTEROID_COUNT = 8;
   localparam int unsigned ADDR_W         = 10;
   localparam int unsigned SLOT_W         = $clog2(ASTEROID_COUNT);

   // Sprite-select code width and table entry field positions.
   localparam int unsigned ENTITY_SIZE = 3;
   localparam int unsigned LIVE_BIT    = 33;

   // Non-zero LFSR start value; also the first sprite code after reset.
   localparam logic [ENTITY_SIZE-1:0] LFSR_SEED = 3'b001;

   typedef enum logic [1:0] {
      StArb,
      StDel,
      StSpwn,
      StCool
   } sched_state_e;

endpackage

// File: rtl/sprite_lfsr.sv
// 3-bit maximal-length LFSR (x^3 + x^2 + 1) producing sprite-select codes.
module sprite_lfsr
   import asteroid_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   seed_load_i,
   input  logic [ENTITY_SIZE-1:0] seed_i,
   input  logic                   advance_i,
   output logic [ENTITY_SIZE-1:0] value_o
);

   logic [ENTITY_SIZE-1:0] lfsr_q, lfsr_d;

   // Next value: reload from seed (zero is locked out), or shift in the tap XOR.
   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load_i) begin
         lfsr_d = (seed_i == '0) ? LFSR_SEED : seed_i;
      end else if (advance_i) begin
         lfsr_d = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
      end
   end

   // State register, async reset to the fixed seed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value_o = lfsr_q;

endmodule

// File: rtl/asteroid_scheduler.sv
// Asteroid table sequencer: arbitrates collision deletes, paces spawns and
// movement to video frames, and issues at most one table command per cycle.
module asteroid_scheduler
   import asteroid_pkg::*;
#(
   parameter int unsigned SPAWN_FRAMES = 60,
   parameter int unsigned MOVE_DIV     = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      frame_start,
   input  logic                      game_en,
   input  logic [ASTEROID_COUNT-1:0] alive_mask,
   input  logic                      bullet_hit_valid,
   input  logic [ADDR_W-1:0]         bullet_hit_addr,
   output logic                      bullet_hit_ready,
   input  logic                      ship_hit_valid,
   input  logic [ADDR_W-1:0]         ship_hit_addr,
   output logic                      ship_hit_ready,
   output logic                      delete_asteroid,
   output logic [ADDR_W-1:0]         asteroid_address,
   output logic                      spawn_en,
   output logic [ENTITY_SIZE-1:0]    entity_byte,
   output logic                      move_tick,
   output logic [7:0]                kill_count
);

   localparam int unsigned FRAME_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
   localparam int unsigned MOVE_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SPAWN_FRAMES - 1);
   localparam logic [MOVE_W-1:0]  MOVE_LAST  = MOVE_W'(MOVE_DIV - 1);

   sched_state_e        state_q, state_d;
   logic                bullet_pend_q, bullet_pend_d;
   logic [ADDR_W-1:0]   bullet_addr_q, bullet_addr_d;
   logic                ship_pend_q, ship_pend_d;
   logic [ADDR_W-1:0]   ship_addr_q, ship_addr_d;
   logic                last_ship_q, last_ship_d;   // 0: bullet was granted last
   logic                grant_ship_q, grant_ship_d; // source served by the DEL cycle
   logic                spawn_due_q, spawn_due_d;
   logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [MOVE_W-1:0]   move_cnt_q, move_cnt_d;
   logic                move_tick_q, move_tick_d;
   logic [7:0]          kill_q, kill_d;

   logic                bullet_accept, ship_accept;
   logic [ADDR_W-1:0]   grant_addr;
   logic                target_ok, in_del, issue_del, table_full, frame_tick;
   logic [ENTITY_SIZE-1:0] lfsr_value;

   assign bullet_accept = bullet_hit_valid && !bullet_pend_q;
   assign ship_accept   = ship_hit_valid && !ship_pend_q;
   assign grant_addr    = grant_ship_q ? ship_addr_q : bullet_addr_q;
   assign target_ok     = (grant_addr < ADDR_W'(ASTEROID_COUNT)) &&
                          alive_mask[grant_addr[SLOT_W-1:0]];
   assign in_del        = (state_q == StDel);
   assign issue_del     = in_del && target_ok;
   assign table_full    = &alive_mask;
   assign frame_tick    = frame_start && game_en;

   sprite_lfsr u_sprite_lfsr (
      .clk_i       (clk),
      .rst_i       (reset_n),
      .seed_load_i (1'b0),
      .seed_i      (LFSR_SEED),
      .advance_i   (state_q == StSpwn),
      .value_o     (lfsr_value)
   );

   // Command FSM with round-robin delete grant. COOL arbitrates like ARB so
   // back-to-back commands land two cycles apart, but never issues itself.
   always_comb begin
      state_d      = state_q;
      grant_ship_d = grant_ship_q;
      last_ship_d  = last_ship_q;
      unique case (state_q)
         StArb, StCool: begin
            if (bullet_pend_q || ship_pend_q) begin
               state_d = StDel;
               if (bullet_pend_q && ship_pend_q) begin
                  grant_ship_d = !last_ship_q;
               end else begin
                  grant_ship_d = ship_pend_q;
               end
               last_ship_d = grant_ship_d;
            end else if (spawn_due_q && game_en && !table_full) begin
               state_d = StSpwn;
            end else begin
               state_d = StArb;
            end
         end
         StDel:   state_d = StCool;
         StSpwn:  state_d = StCool;
         default: state_d = StArb;
      endcase
   end

   // Request holding slots and kill counter; a slot frees when its DEL cycle ends.
   always_comb begin
      bullet_pend_d = bullet_pend_q;
      bullet_addr_d = bullet_addr_q;
      ship_pend_d   = ship_pend_q;
      ship_addr_d   = ship_addr_q;
      kill_d        = kill_q;
      if (in_del && !grant_ship_q) bullet_pend_d = 1'b0;
      if (in_del && grant_ship_q)  ship_pend_d   = 1'b0;
      if (bullet_accept) begin
         bullet_pend_d = 1'b1;
         bullet_addr_d = bullet_hit_addr;
      end
      if (ship_accept) begin
         ship_pend_d = 1'b1;
         ship_addr_d = ship_hit_addr;
      end
      if (issue_del && !grant_ship_q && (kill_q != 8'hFF)) begin
         kill_d = kill_q + 8'd1;
      end
   end

   // Frame-paced spawn request and movement tick; a new spawn_due beats the clear.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      spawn_due_d = spawn_due_q;
      move_cnt_d  = move_cnt_q;
      move_tick_d = 1'b0;
      if (state_q == StSpwn) spawn_due_d = 1'b0;
      if (frame_tick) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            spawn_due_d = 1'b1;
         end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
         end
         if (move_cnt_q == MOVE_LAST) begin
            move_cnt_d  = '0;
            move_tick_d = 1'b1;
         end else begin
            move_cnt_d = move_cnt_q + MOVE_W'(1);
         end
      end
   end

   // State registers, async active-high reset.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q       <= StArb;
         bullet_pend_q <= 1'b0;
         bullet_addr_q <= '0;
         ship_pend_q   <= 1'b0;
         ship_addr_q   <= '0;
         last_ship_q   <= 1'b0;
         grant_ship_q  <= 1'b0;
         spawn_due_q   <= 1'b0;
         frame_cnt_q   <= '0;
         move_cnt_q    <= '0;
         move_tick_q   <= 1'b0;
         kill_q        <= '0;
      end else begin
         state_q       <= state_d;
         bullet_pend_q <= bullet_pend_d;
         bullet_addr_q <= bullet_addr_d;
         ship_pend_q   <= ship_pend_d;
         ship_addr_q   <= ship_addr_d;
         last_ship_q   <= last_ship_d;
         grant_ship_q  <= grant_ship_d;
         spawn_due_q   <= spawn_due_d;
         frame_cnt_q   <= frame_cnt_d;
         move_cnt_q    <= move_cnt_d;
         move_tick_q   <= move_tick_d;
         kill_q        <= kill_d;
      end
   end

   assign bullet_hit_ready = !bullet_pend_q;
   assign ship_hit_ready   = !ship_pend_q;
   assign delete_asteroid  = issue_del;
   assign asteroid_address = issue_del ? grant_addr : '0;
   assign spawn_en         = (state_q == StSpwn);
   assign entity_byte      = lfsr_value;
   assign move_tick        = move_tick_q;
   assign kill_count       = kill_q;

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Directed self-checking bench for asteroid_scheduler.
module tb_asteroid_scheduler;
   import asteroid_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic                      frame_start;
   logic                      game_en;
   logic [ASTEROID_COUNT-1:0] alive_mask;
   logic                      bullet_hit_valid;
   logic [ADDR_W-1:0]         bullet_hit_addr;
   logic                      bullet_hit_ready;
   logic                      ship_hit_valid;
   logic [ADDR_W-1:0]         ship_hit_addr;
   logic                      ship_hit_ready;
   logic                      delete_asteroid;
   logic [ADDR_W-1:0]         asteroid_address;
   logic                      spawn_en;
   logic [ENTITY_SIZE-1:0]    entity_byte;
   logic                      move_tick;
   logic [7:0]                kill_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_move = 0;
   int t0;
   logic prev_fs = 1'b0;
   int del_cyc[$];
   int del_addr[$];
   int spawn_cyc[$];
   int spawn_ent[$];

   always #5 clk = ~clk;

   asteroid_scheduler #(
      .SPAWN_FRAMES (60),
      .MOVE_DIV     (2)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .frame_start      (frame_start),
      .game_en          (game_en),
      .alive_mask       (alive_mask),
      .bullet_hit_valid (bullet_hit_valid),
      .bullet_hit_addr  (bullet_hit_addr),
      .bullet_hit_ready (bullet_hit_ready),
      .ship_hit_valid   (ship_hit_valid),
      .ship_hit_addr    (ship_hit_addr),
      .ship_hit_ready   (ship_hit_ready),
      .delete_asteroid  (delete_asteroid),
      .asteroid_address (asteroid_address),
      .spawn_en         (spawn_en),
      .entity_byte      (entity_byte),
      .move_tick        (move_tick),
      .kill_count       (kill_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic frame_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         drive_edge();
         frame_start = 1'b1;
         drive_edge();
         frame_start = 1'b0;
         drive_edge();
         drive_edge();
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Event log of command pulses and movement ticks.
   always @(negedge clk) begin
      if (move_tick) begin
         n_move++;
         check("tick_after_frame_start", 32'(prev_fs), 32'd1);
      end
      prev_fs = frame_start;
      if (delete_asteroid) begin
         del_cyc.push_back(cyc);
         del_addr.push_back(32'(asteroid_address));
      end
      if (spawn_en) begin
         spawn_cyc.push_back(cyc);
         spawn_ent.push_back(32'(entity_byte));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n          = 1'b0;
      frame_start      = 1'b0;
      game_en          = 1'b0;
      alive_mask       = 8'hFF;
      bullet_hit_valid = 1'b0;
      bullet_hit_addr  = '0;
      ship_hit_valid   = 1'b0;
      ship_hit_addr    = '0;
      #2 reset_n = 1'b1;
      repeat (2) drive_edge();
      reset_n = 1'b0;

      // Reset state
      sample();
      check("rst_b_ready", 32'(bullet_hit_ready), 32'd1);
      check("rst_s_ready", 32'(ship_hit_ready), 32'd1);
      check("rst_entity", 32'(entity_byte), 32'd1);
      check("rst_kill", 32'(kill_count), 32'd0);
      check("rst_delete", 32'(delete_asteroid), 32'd0);
      check("rst_spawn", 32'(spawn_en), 32'd0);
      check("rst_move", 32'(move_tick), 32'd0);
      check("rst_addr", 32'(asteroid_address), 32'd0);

      // Single bullet hit on slot 3
      drive_edge();
      bullet_hit_valid = 1'b1;
      bullet_hit_addr  = 10'd3;
      sample();
      check("b1_ready_t", 32'(bullet_hit_ready), 32'd1);
      drive_edge();
      bullet_hit_valid = 1'b0;
      sample();
      check("b1_ready_t1", 32'(bullet_hit_ready), 32'd0);
      check("b1_del_t1", 32'(delete_asteroid), 32'd0);
      sample();
      check("b1_del_t2", 32'(delete_asteroid), 32'd1);
      check("b1_addr_t2", 32'(asteroid_address), 32'd3);
      sample();
      check("b1_ready_t3", 32'(bullet_hit_ready), 32'd1);
      check("b1_kill", 32'(kill_count), 32'd1);
      check("b1_del_t3", 32'(delete_asteroid), 32'd0);
      drive_edge();
      check("b1_pulses", 32'(del_cyc.size()), 32'd1);
      del_cyc.delete();
      del_addr.delete();

      // Out-of-range target
      drive_edge();
      bullet_hit_valid = 1'b1;
      bullet_hit_addr  = 10'd9;
      drive_edge();
      bullet_hit_valid = 1'b0;
      repeat (5) drive_edge();
      check("inv_range_pulses", 32'(del_cyc.size()), 32'd0);
      check("inv_range_kill", 32'(kill_count), 32'd1);
      check("inv_range_ready", 32'(bullet_hit_ready), 32'd1);

      // Dead target
      alive_mask       = 8'hEF;
      bullet_hit_valid = 1'b1;
      bullet_hit_addr  = 10'd4;
      drive_edge();
      bullet_hit_valid = 1'b0;
      repeat (5) drive_edge();
      check("inv_dead_pulses", 32'(del_cyc.size()), 32'd0);
      check("inv_dead_kill", 32'(kill_count), 32'd1);
      check("inv_dead_ready", 32'(bullet_hit_ready), 32'd1);
      alive_mask = 8'hFF;

      // Reset in the middle of a delete; the other pending request is lost
      drive_edge();
      ship_hit_valid   = 1'b1;
      ship_hit_addr    = 10'd6;
      bullet_hit_valid = 1'b1;
      bullet_hit_addr  = 10'd1;
      drive_edge();
      ship_hit_valid   = 1'b0;
      bullet_hit_valid = 1'b0;
      sample();
      sample();
      check("mid_del_pulse", 32'(delete_asteroid), 32'd1);
      check("mid_del_addr", 32'(asteroid_address), 32'd6);
      #1 reset_n = 1'b1;
      #1;
      check("mid_rst_delete", 32'(delete_asteroid), 32'd0);
      check("mid_rst_kill", 32'(kill_count), 32'd0);
      check("mid_rst_b_ready", 32'(bullet_hit_ready), 32'd1);
      check("mid_rst_s_ready", 32'(ship_hit_ready), 32'd1);
      check("mid_rst_entity", 32'(entity_byte), 32'd1);
      drive_edge();
      reset_n = 1'b0;
      repeat (6) drive_edge();
      check("mid_rst_lost", 32'(del_cyc.size()), 32'd1);
      del_cyc.delete();
      del_addr.delete();

      // Tie: ship wins first after reset, bullet two cycles later
      drive_edge();
      t0 = cyc;
      ship_hit_valid   = 1'b1;
      ship_hit_addr    = 10'd5;
      bullet_hit_valid = 1'b1;
      bullet_hit_addr  = 10'd2;
      drive_edge();
      ship_hit_valid   = 1'b0;
      bullet_hit_valid = 1'b0;
      repeat (8) drive_edge();
      check("tie_count", 32'(del_cyc.size()), 32'd2);
      if (del_cyc.size() == 2) begin
         check("tie_first_lat", 32'(del_cyc[0] - t0), 32'd2);
         check("tie_first_addr", 32'(del_addr[0]), 32'd5);
         check("tie_second_lat", 32'(del_cyc[1] - t0), 32'd4);
         check("tie_second_addr", 32'(del_addr[1]), 32'd2);
      end
      check("tie_kill", 32'(kill_count), 32'd1);

      // Spawn pacing with free slots
      game_en    = 1'b1;
      alive_mask = 8'h0F;
      n_move     = 0;
      frame_pulses(59);
      repeat (4) drive_edge();
      check("spawn_59_none", 32'(spawn_cyc.size()), 32'd0);
      frame_pulses(1);
      repeat (4) drive_edge();
      check("spawn_60_count", 32'(spawn_cyc.size()), 32'd1);
      if (spawn_ent.size() >= 1) check("spawn_60_ent", 32'(spawn_ent[0]), 32'd1);
      frame_pulses(60);
      repeat (4) drive_edge();
      check("spawn_120_count", 32'(spawn_cyc.size()), 32'd2);
      if (spawn_ent.size() >= 2) check("spawn_120_ent", 32'(spawn_ent[1]), 32'd2);
      check("move_120_ticks", 32'(n_move), 32'd60);

      // Table full: spawn held until a slot frees
      alive_mask = 8'hFF;
      frame_pulses(60);
      repeat (10) drive_edge();
      check("full_no_spawn", 32'(spawn_cyc.size()), 32'd2);
      alive_mask = 8'hFE;
      t0 = cyc;
      repeat (4) drive_edge();
      check("full_spawn_count", 32'(spawn_cyc.size()), 32'd3);
      if (spawn_cyc.size() >= 3) begin
         check("full_spawn_lat", 32'(spawn_cyc[2] - t0), 32'd1);
         check("full_spawn_ent", 32'(spawn_ent[2]), 32'd5);
      end

      // Movement ticks gated by game_en
      n_move  = 0;
      game_en = 1'b0;
      frame_pulses(6);
      repeat (2) drive_edge();
      check("move_disabled", 32'(n_move), 32'd0);
      check("spawn_disabled", 32'(spawn_cyc.size()), 32'd3);
      game_en = 1'b1;
      frame_pulses(6);
      repeat (2) drive_edge();
      check("move_enabled", 32'(n_move), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
